// File: rtl/serv_seq_pkg.sv
// Shared types and constants for the SERV bit-serial instruction sequencer.
package serv_seq_pkg;

  localparam int unsigned CNT_W    = 5;
  localparam int unsigned CNT_LAST = 31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    MEM  = 2'd2,
    RUN  = 2'd3
  } state_e;

endpackage

// File: rtl/serv_seq_cnt.sv
// 32-phase bit-serial counter with enable, synchronous clear and phase strobes.
module serv_seq_cnt
  import serv_seq_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_cnt0,
  output logic             o_cnt1,
  output logic             o_cnt_done
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Wraps naturally from the last phase back to 0 so INIT flows into RUN.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt      = cnt_q;
  assign o_cnt0     = i_en & (cnt_q == CNT_W'(0));
  assign o_cnt1     = i_en & (cnt_q == CNT_W'(1));
  assign o_cnt_done = i_en & (cnt_q == CNT_W'(CNT_LAST));

endmodule

// File: rtl/serv_seq_ctrl.sv
// SERV instruction sequencer: IDLE -> [INIT -> [MEM]] -> RUN, driving the phase
// counter strobes, bufreg shift enable and the data-bus cycle request.
module serv_seq_ctrl
  import serv_seq_pkg::*;
#(
  parameter int unsigned W = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_two_stage,
  input  logic             i_mem_op,
  input  logic             i_bufreg_run,
  input  logic             i_dbus_ack,
  output logic             o_busy,
  output logic             o_init,
  output logic             o_cnt_en,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_cnt0,
  output logic             o_cnt1,
  output logic             o_cnt_done,
  output logic             o_bufreg_en,
  output logic             o_dbus_cyc,
  output logic             o_done
);

  if (W != 1) begin : g_w_check
    $error("serv_seq_ctrl: only W=1 is supported");
  end

  state_e state_q;
  state_e state_d;
  logic   mem_q;
  logic   mem_d;
  logic   cnt_en;
  logic   cnt_done;

  // Next-state logic; mem_op only matters for two-stage instructions.
  always_comb begin
    state_d = state_q;
    mem_d   = mem_q;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          mem_d   = i_mem_op & i_two_stage;
          state_d = i_two_stage ? INIT : RUN;
        end
      end
      INIT: begin
        if (cnt_done) begin
          state_d = mem_q ? MEM : RUN;
        end
      end
      MEM: begin
        if (i_dbus_ack) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      mem_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
    end
  end

  assign cnt_en = (state_q == INIT) | (state_q == RUN);

  serv_seq_cnt u_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_en       (cnt_en),
    .i_clr      (~cnt_en),
    .o_cnt      (o_cnt),
    .o_cnt0     (o_cnt0),
    .o_cnt1     (o_cnt1),
    .o_cnt_done (cnt_done)
  );

  // Outputs are pure decodes so an asynchronous reset clears them at once.
  assign o_busy      = (state_q != IDLE);
  assign o_init      = (state_q == INIT);
  assign o_cnt_en    = cnt_en;
  assign o_cnt_done  = cnt_done;
  assign o_bufreg_en = cnt_en & (o_init | i_bufreg_run);
  assign o_dbus_cyc  = (state_q == MEM);
  assign o_done      = cnt_done & (state_q == RUN);

endmodule

// File: tb/tb_serv_seq_ctrl.sv
// Randomized scoreboard bench for serv_seq_ctrl against a per-instruction cycle model.
module tb_serv_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_start = 1'b0;
  logic       i_two_stage = 1'b0;
  logic       i_mem_op = 1'b0;
  logic       i_bufreg_run = 1'b0;
  logic       i_dbus_ack = 1'b0;
  logic       o_busy, o_init, o_cnt_en, o_cnt0, o_cnt1, o_cnt_done;
  logic       o_bufreg_en, o_dbus_cyc, o_done;
  logic [4:0] o_cnt;

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct packed {
    int unsigned cyc;
    logic [12:0] v;
  } exp_t;

  exp_t exp_q[$];

  serv_seq_ctrl #(.W(1)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (i_start),
    .i_two_stage  (i_two_stage),
    .i_mem_op     (i_mem_op),
    .i_bufreg_run (i_bufreg_run),
    .i_dbus_ack   (i_dbus_ack),
    .o_busy       (o_busy),
    .o_init       (o_init),
    .o_cnt_en     (o_cnt_en),
    .o_cnt        (o_cnt),
    .o_cnt0       (o_cnt0),
    .o_cnt1       (o_cnt1),
    .o_cnt_done   (o_cnt_done),
    .o_bufreg_en  (o_bufreg_en),
    .o_dbus_cyc   (o_dbus_cyc),
    .o_done       (o_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected output vector for one active cycle of a pass at phase k.
  function automatic logic [12:0] mk(input bit init, input bit en, input int k,
                                     input bit brun, input bit dbus, input bit run);
    logic [4:0] c;
    c = en ? 5'(k) : 5'd0;
    return {init, en, c, en && k == 0, en && k == 1, en && k == 31,
            en && (init || brun), dbus, run && k == 31};
  endfunction

  // Monitor: pops one expectation per busy cycle, checks idle outputs otherwise.
  always @(negedge clk) begin
    logic [12:0] act;
    exp_t        e;
    act = {o_init, o_cnt_en, o_cnt, o_cnt0, o_cnt1, o_cnt_done,
           o_bufreg_en, o_dbus_cyc, o_done};
    checks++;
    if (o_busy) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL busy_unexpected cyc=%0d outputs=%h required=idle", cyc, act);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.v != act) begin
          errors++;
          $display("FAIL active_cycle cyc=%0d outputs=%h required cyc=%0d outputs=%h",
                   cyc, act, e.cyc, e.v);
        end
      end
    end else begin
      if (act != 13'd0 || o_cnt != 5'd0) begin
        errors++;
        $display("FAIL idle_outputs cyc=%0d outputs=%h required=0", cyc, act);
      end
      if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_active cyc=%0d busy=0 required busy=1 outputs=%h", cyc, e.v);
      end
    end
  end

  // Issue one instruction from an IDLE cycle; abort_at>0 pulses reset in that active cycle.
  task automatic do_instr(input bit two, input bit mem, input int hold, input bit brun,
                          input int abort_at, input int gap);
    int   total;
    int   mem_lo;
    int   mem_hi;
    bit   eff_mem;
    exp_t e;
    eff_mem      = two && mem;
    i_start      = 1'b1;
    i_two_stage  = two;
    i_mem_op     = mem;
    i_bufreg_run = brun;
    i_dbus_ack   = 1'($urandom);
    total        = 0;
    if (two) begin
      for (int k = 0; k < 32; k++) begin
        e.cyc = cyc + 1 + 32'(total); e.v = mk(1, 1, k, brun, 0, 0);
        exp_q.push_back(e); total++;
      end
    end
    mem_lo = total + 1;
    mem_hi = total;
    if (eff_mem) begin
      for (int k = 0; k <= hold; k++) begin
        e.cyc = cyc + 1 + 32'(total); e.v = mk(0, 0, 0, brun, 1, 0);
        exp_q.push_back(e); total++;
      end
      mem_hi = total;
    end
    for (int k = 0; k < 32; k++) begin
      e.cyc = cyc + 1 + 32'(total); e.v = mk(0, 1, k, brun, 0, 1);
      exp_q.push_back(e); total++;
    end
    for (int i = 1; i <= total; i++) begin
      @(posedge clk); #1;
      i_start     = (gap == 0) ? 1'b1 : 1'($urandom);
      i_two_stage = 1'($urandom);
      i_mem_op    = 1'($urandom);
      if (eff_mem && i >= mem_lo && i <= mem_hi) i_dbus_ack = (i == mem_hi);
      else i_dbus_ack = 1'($urandom);
      if (i == abort_at) begin
        exp_q.delete();
        rst = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    rst        = 1'b0;
    i_start    = 1'b0;
    i_dbus_ack = 1'($urandom);
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    do_instr(0, 0, 0, 0, 0, 2);   // single-stage
    do_instr(1, 0, 0, 0, 0, 1);   // two-stage, no memory
    do_instr(1, 1, 5, 1, 0, 1);   // load, ack held off 5 cycles
    do_instr(1, 1, 0, 0, 0, 1);   // ack in first MEM cycle
    do_instr(0, 1, 0, 1, 0, 1);   // mem_op without two_stage
    do_instr(1, 1, 8, 0, 36, 1);  // reset mid-MEM
    do_instr(0, 0, 0, 1, 18, 1);  // reset at RUN cnt=17
    do_instr(1, 0, 0, 1, 10, 1);  // reset mid-INIT
    do_instr(1, 0, 0, 1, 50, 1);  // reset at RUN cnt=17 after INIT
    do_instr(0, 0, 0, 1, 0, 0);   // back-to-back with start held
    do_instr(1, 1, 2, 0, 0, 0);
    do_instr(0, 0, 0, 0, 0, 1);

    for (int n = 0; n < 25; n++) begin
      bit two, mem, brun;
      int hold, ab, gap;
      two  = 1'($urandom);
      mem  = 1'($urandom);
      brun = 1'($urandom);
      hold = $urandom_range(0, 6);
      ab   = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 32) : 0;
      gap  = $urandom_range(0, 3);
      do_instr(two, mem, hold, brun, ab, gap);
    end

    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expect pending=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serv_seq_ctrl.md
Name: serv_seq_ctrl

Overview:
- Bit-serial instruction sequencer for the SERV core. Sits directly upstream of serv_bufreg.
- Generates the 32-cycle phase counter and its decoded strobes: cnt_en, cnt0, cnt1, cnt_done, plus the init flag and the bufreg shift enable.
- Sequences two-stage instructions through an init pass, an optional data-bus wait, and a run pass.
- Owns the dbus cycle request that presents the buffered address to memory.

Parameters:
- W, 1, datapath width per cycle; only 1 is supported, any other value raises an elaboration error.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_start  in  1  decoded instruction with operands ready; sampled only in IDLE
- i_two_stage  in  1  instruction needs an init pass (mem, shift, branch); sampled with i_start
- i_mem_op  in  1  load/store; sampled with i_start
- i_bufreg_run  in  1  bufreg also shifts during the run pass
- i_dbus_ack  in  1  memory acknowledge
- o_busy  out  1  state is not IDLE
- o_init  out  1  state is INIT
- o_cnt_en  out  1  state is INIT or RUN
- o_cnt  out  5  phase counter value
- o_cnt0  out  1  o_cnt==0 & o_cnt_en
- o_cnt1  out  1  o_cnt==1 & o_cnt_en
- o_cnt_done  out  1  o_cnt==31 & o_cnt_en
- o_bufreg_en  out  1  o_cnt_en & (o_init | i_bufreg_run)
- o_dbus_cyc  out  1  state is MEM
- o_done  out  1  o_cnt_done & state is RUN

Behaviour:
- Reset (async, any state):
  - state=IDLE, counter=0, latched mode bits=0.
  - All outputs 0 except o_cnt=0.
- States: IDLE, INIT, MEM, RUN. Registered state and counter; all outputs are combinational decodes of state, counter and i_bufreg_run.
- IDLE:
  - When i_start=1, latch i_two_stage and i_mem_op.
  - Next state is INIT if i_two_stage=1, else RUN.
  - i_start=0 stays in IDLE.
- INIT:
  - Counter increments every cycle.
  - At o_cnt_done: go to MEM if latched mem_op=1, else go straight to RUN. RUN begins the next cycle with the counter wrapped to 0, with no gap cycle.
- MEM:
  - Counter holds at 0 and o_cnt_en=0; o_dbus_cyc=1.
  - On i_dbus_ack=1, go to RUN at the next edge.
  - Minimum residency is 1 cycle: an ack in the first MEM cycle is accepted.
  - o_dbus_cyc deasserts in the cycle after the ack.
- RUN:
  - Counter increments every cycle.
  - At o_cnt_done, o_done=1 for that single cycle; next state is IDLE.
- Counter:
  - 5 bits; increments only when o_cnt_en; wraps 31->0 modulo 32.
  - Always 0 in IDLE and MEM.
- Latency from the i_start edge:
  - Single-stage: 32 active cycles; o_done in the 32nd.
  - Two-stage, non-mem: 64 contiguous active cycles.
  - Mem: 32 INIT + N MEM (N>=1) + 32 RUN.
- Ignored inputs:
  - i_start outside IDLE is ignored.
  - i_dbus_ack outside MEM is ignored.
  - i_two_stage and i_mem_op changes after acceptance have no effect.
- Simultaneous events:
  - i_start in the same cycle as o_done is ignored, because state is still RUN; it is accepted the following cycle.
  - Reset asserted mid-INIT, mid-MEM or mid-RUN aborts immediately: o_dbus_cyc drops asynchronously and no o_done is issued.
- i_mem_op=1 with i_two_stage=0 is treated as single-stage; MEM is never entered.

Decomposition:
- Package serv_seq_pkg:
  - state encoding constants IDLE=0, INIT=1, MEM=2, RUN=3 (2-bit)
  - CNT_W=5
  - CNT_LAST=31
- Sub-module serv_seq_cnt:
  - 5-bit counter with enable and synchronous clear.
  - Decodes cnt0, cnt1 and cnt_done.
  - Top level keeps the FSM and output gating.

Test Plan:
- Reset then single-stage start (i_start=1, i_two_stage=0) -> o_cnt_en high 32 cycles, o_cnt 0..31, o_cnt0 in cycle 1, o_cnt1 in cycle 2, o_done with o_cnt=31, then o_busy=0.
- Two-stage non-mem -> o_init=1 for 32 cycles, o_bufreg_en=1 throughout INIT; RUN starts next cycle with o_cnt=0 and o_init=0; o_done at active cycle 64.
- Two-stage load, ack held off 5 cycles -> o_dbus_cyc=1 for exactly 6 cycles, o_cnt_en=0 and o_cnt=0 during MEM; RUN follows with 32 counts.
- Ack in first MEM cycle -> o_dbus_cyc high exactly 1 cycle; spurious ack in IDLE/RUN -> no state change.
- Reset pulsed mid-MEM and at o_cnt=17 of RUN -> all outputs 0 immediately, no o_done; new i_start afterwards runs normally.
- i_start held high continuously -> instructions back-to-back with exactly 1 IDLE cycle between o_done and the next o_cnt0.
